// File: rtl/bsg_scheduler_resource_avail.sv
// Per-resource slot tracker: allocates dependency slots, raises avail_o[i] on completion and frees slots once closed with no references left.
// Optional zero-latency wakeup via `BSG_SCHEDULER_RESOURCE_AVAIL_BYPASS_EN; avail/alloc outputs decode registered state otherwise.
module bsg_scheduler_resource_avail #(
    parameter int max_dep_bits_p   = 8,
    parameter int refcount_width_p = 4,
    localparam int idx_width_lp    = (max_dep_bits_p > 1) ? $clog2(max_dep_bits_p) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    output logic [max_dep_bits_p-1:0] avail_o,
    output logic                      alloc_v_o,
    output logic [idx_width_lp-1:0]   alloc_idx_o,
    input  logic                      alloc_yumi_i,
    input  logic                      complete_v_i,
    input  logic [idx_width_lp-1:0]   complete_idx_i,
    input  logic                      ref_v_i,
    input  logic [idx_width_lp-1:0]   ref_idx_i,
    input  logic                      release_v_i,
    input  logic [idx_width_lp-1:0]   release_idx_i,
    input  logic                      close_v_i,
    input  logic [idx_width_lp-1:0]   close_idx_i
);

    typedef enum logic [1:0] {FREE = 2'd0, PENDING = 2'd1, READY = 2'd2} slot_state_e;

    slot_state_e                 state_q [max_dep_bits_p];
    slot_state_e                 state_d [max_dep_bits_p];
    logic [max_dep_bits_p-1:0]   closed_q, closed_d;
    logic [refcount_width_p-1:0] count_q [max_dep_bits_p];
    logic [refcount_width_p-1:0] count_d [max_dep_bits_p];
    logic bad_complete, bad_ref, bad_release, bad_close;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < max_dep_bits_p; i++) begin
                state_q[i] <= FREE;
                count_q[i] <= '0;
            end
            closed_q <= '0;
        end else begin
            for (int i = 0; i < max_dep_bits_p; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
            end
            closed_q <= closed_d;
        end
    end

    always_comb begin
        closed_d     = closed_q;
        bad_complete = 1'b0;
        bad_ref      = 1'b0;
        bad_release  = 1'b0;
        bad_close    = 1'b0;
        for (int i = 0; i < max_dep_bits_p; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
        end
        // Slot 0 is permanently available and never touched.
        for (int i = 1; i < max_dep_bits_p; i++) begin
            logic hit_alloc, hit_cmp, hit_ref, hit_rel, hit_close, free_now;
            hit_alloc = alloc_yumi_i && alloc_v_o && (alloc_idx_o == idx_width_lp'(i));
            hit_cmp   = complete_v_i && (complete_idx_i == idx_width_lp'(i));
            hit_ref   = ref_v_i && (ref_idx_i == idx_width_lp'(i));
            hit_rel   = release_v_i && (release_idx_i == idx_width_lp'(i));
            hit_close = close_v_i && (close_idx_i == idx_width_lp'(i));
            free_now  = (state_q[i] == READY) && closed_q[i] && (count_q[i] == '0);

            if (hit_cmp && state_q[i] != PENDING) bad_complete = 1'b1;
            if (hit_ref && !hit_rel && (state_q[i] == FREE || count_q[i] == '1)) bad_ref = 1'b1;
            if (hit_rel && !hit_ref && count_q[i] == '0) bad_release = 1'b1;
            if (hit_close && state_q[i] == FREE) bad_close = 1'b1;

            if (free_now) begin
                state_d[i]  = FREE;
                closed_d[i] = 1'b0;
                count_d[i]  = '0;
            end else if (hit_alloc) begin
                state_d[i]  = PENDING;
                closed_d[i] = 1'b0;
                count_d[i]  = '0;
            end else if (state_q[i] != FREE) begin
                if (hit_cmp && state_q[i] == PENDING) state_d[i] = READY;
                if (hit_close) closed_d[i] = 1'b1;
                // A paired ref+release nets to zero, so neither saturation check applies.
                if (hit_ref && !hit_rel && count_q[i] != '1)
                    count_d[i] = count_q[i] + refcount_width_p'(1);
                else if (hit_rel && !hit_ref && count_q[i] != '0)
                    count_d[i] = count_q[i] - refcount_width_p'(1);
            end
        end
    end

    always_comb begin
        alloc_v_o   = 1'b0;
        alloc_idx_o = '0;
        avail_o     = '0;
        avail_o[0]  = 1'b1;
        for (int i = max_dep_bits_p - 1; i >= 1; i--) begin
            if (state_q[i] == FREE) begin
                alloc_v_o   = 1'b1;
                alloc_idx_o = idx_width_lp'(i);
            end
        end
        for (int i = 1; i < max_dep_bits_p; i++) begin
`ifdef BSG_SCHEDULER_RESOURCE_AVAIL_BYPASS_EN
            avail_o[i] = (state_q[i] == READY)
                       || (complete_v_i && (complete_idx_i == idx_width_lp'(i)) && state_q[i] == PENDING);
`else
            avail_o[i] = (state_q[i] == READY);
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(alloc_yumi_i && !alloc_v_o));
            assert (!bad_complete);
            assert (!bad_ref);
            assert (!bad_release);
            assert (!bad_close);
        end
    end

endmodule

// File: tb/tb_bsg_scheduler_resource_avail.sv
// Directed bench for bsg_scheduler_resource_avail (8 slots) with a slot-level reference model checked every cycle.
module tb_bsg_scheduler_resource_avail;
    localparam int N  = 8;
    localparam int IW = 3;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_i;
    logic [N-1:0]  avail_o;
    logic          alloc_v_o;
    logic [IW-1:0] alloc_idx_o;
    logic          alloc_yumi_i, complete_v_i, ref_v_i, release_v_i, close_v_i;
    logic [IW-1:0] complete_idx_i, ref_idx_i, release_idx_i, close_idx_i;

    bsg_scheduler_resource_avail #(.max_dep_bits_p(N), .refcount_width_p(4)) dut (
        .clk_i(clk), .reset_i(reset_i), .avail_o(avail_o),
        .alloc_v_o(alloc_v_o), .alloc_idx_o(alloc_idx_o), .alloc_yumi_i(alloc_yumi_i),
        .complete_v_i(complete_v_i), .complete_idx_i(complete_idx_i),
        .ref_v_i(ref_v_i), .ref_idx_i(ref_idx_i),
        .release_v_i(release_v_i), .release_idx_i(release_idx_i),
        .close_v_i(close_v_i), .close_idx_i(close_idx_i)
    );

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    // Model: 0 = free, 1 = waiting for result, 2 = result ready.
    int m_state [N];
    bit m_closed [N];
    int m_count [N];
    bit freeing [N];
    int lo;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_lowest();
        for (int s = 1; s < N; s++) if (m_state[s] == 0) return s;
        return 0;
    endfunction

    function automatic logic [N-1:0] m_avail();
        logic [N-1:0] r;
        r = 1;
        for (int s = 1; s < N; s++) if (m_state[s] == 2) r[s] = 1'b1;
`ifdef BSG_SCHEDULER_RESOURCE_AVAIL_BYPASS_EN
        if (complete_v_i && complete_idx_i != 0 && m_state[complete_idx_i] == 1) r[complete_idx_i] = 1'b1;
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset_i) begin
            for (int s = 0; s < N; s++) begin
                m_state[s] = 0; m_closed[s] = 0; m_count[s] = 0;
            end
        end else begin
            lo = m_lowest();
            for (int s = 0; s < N; s++)
                freeing[s] = (s != 0) && m_state[s] == 2 && m_closed[s] && m_count[s] == 0;
            if (complete_v_i && complete_idx_i != 0 && !freeing[complete_idx_i] && m_state[complete_idx_i] == 1)
                m_state[complete_idx_i] = 2;
            if (close_v_i && close_idx_i != 0 && !freeing[close_idx_i] && m_state[close_idx_i] != 0)
                m_closed[close_idx_i] = 1;
            if (!(ref_v_i && release_v_i && ref_idx_i == release_idx_i)) begin
                if (ref_v_i && ref_idx_i != 0 && !freeing[ref_idx_i] && m_state[ref_idx_i] != 0 && m_count[ref_idx_i] < CMAX)
                    m_count[ref_idx_i]++;
                if (release_v_i && release_idx_i != 0 && !freeing[release_idx_i] && m_count[release_idx_i] > 0)
                    m_count[release_idx_i]--;
            end
            for (int s = 1; s < N; s++) if (freeing[s]) begin
                m_state[s] = 0; m_closed[s] = 0; m_count[s] = 0;
            end
            if (alloc_yumi_i && lo != 0) begin
                m_state[lo] = 1; m_closed[lo] = 0; m_count[lo] = 0;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (checking) begin
            chk("model_avail", avail_o, m_avail());
            chk("model_alloc_v", alloc_v_o, (m_lowest() != 0));
            if (m_lowest() != 0) chk("model_alloc_idx", alloc_idx_o, m_lowest());
        end
    end

    task automatic clr();
        alloc_yumi_i = 0; complete_v_i = 0; ref_v_i = 0; release_v_i = 0; close_v_i = 0;
        complete_idx_i = 0; ref_idx_i = 0; release_idx_i = 0; close_idx_i = 0;
    endtask

    task automatic op();
        @(negedge clk);
        clr();
    endtask

    initial begin
        clr();
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        checking = 1'b1;
        #1;
        chk("reset_avail", avail_o, 8'h01);
        chk("reset_alloc_v", alloc_v_o, 1);
        chk("reset_alloc_idx", alloc_idx_o, 1);

        alloc_yumi_i = 1; op(); #1;
        chk("yumi_next_idx", alloc_idx_o, 2);
        chk("yumi_avail", avail_o, 8'h01);
        complete_v_i = 1; complete_idx_i = 1; #1;
`ifdef BSG_SCHEDULER_RESOURCE_AVAIL_BYPASS_EN
        chk("complete_same_cycle", avail_o, 8'h03);
`else
        chk("complete_same_cycle", avail_o, 8'h01);
`endif
        op(); #1;
        chk("complete_next_cycle", avail_o, 8'h03);

        repeat (2) begin ref_v_i = 1; ref_idx_i = 1; op(); end
        close_v_i = 1; close_idx_i = 1; op();
        release_v_i = 1; release_idx_i = 1; op(); #1;
        chk("held_one_ref", avail_o, 8'h03);
        release_v_i = 1; release_idx_i = 1; op(); #1;
        chk("last_release_avail", avail_o, 8'h03);
        chk("last_release_idx", alloc_idx_o, 2);
        @(negedge clk); #1;
        chk("freed_avail", avail_o, 8'h01);
        chk("freed_idx", alloc_idx_o, 1);

        repeat (7) begin alloc_yumi_i = 1; op(); end
        #1; chk("all_taken_v", alloc_v_o, 0);
        complete_v_i = 1; complete_idx_i = 5; op(); #1;
        chk("slot5_ready", avail_o, 8'h21);
        close_v_i = 1; close_idx_i = 5; op(); #1;
        chk("slot5_closing_v", alloc_v_o, 0);
        @(negedge clk); #1;
        chk("slot5_free_v", alloc_v_o, 1);
        chk("slot5_free_idx", alloc_idx_o, 5);

        complete_v_i = 1; complete_idx_i = 3; op(); #1;
        chk("slot3_ready", avail_o, 8'h09);
        repeat (2) begin ref_v_i = 1; ref_idx_i = 3; op(); end
        ref_v_i = 1; ref_idx_i = 3; release_v_i = 1; release_idx_i = 3; op();
        close_v_i = 1; close_idx_i = 3; op();
        release_v_i = 1; release_idx_i = 3; op();
        @(negedge clk); #1;
        chk("paired_ref_rel_kept", avail_o, 8'h09);
        release_v_i = 1; release_idx_i = 3; op();
        @(negedge clk); #1;
        chk("slot3_freed", avail_o, 8'h01);
        chk("slot3_lowest", alloc_idx_o, 3);

        alloc_yumi_i = 1; op();
        ref_v_i = 1; ref_idx_i = 2; reset_i = 1; op(); reset_i = 0; #1;
        chk("midreset_avail", avail_o, 8'h01);
        chk("midreset_v", alloc_v_o, 1);
        chk("midreset_idx", alloc_idx_o, 1);

        repeat (2) begin alloc_yumi_i = 1; op(); end
        complete_v_i = 1; complete_idx_i = 1; ref_v_i = 1; ref_idx_i = 2;
        close_v_i = 1; close_idx_i = 2; op(); #1;
        chk("simul_avail", avail_o, 8'h03);
        release_v_i = 1; release_idx_i = 2; op();
        complete_v_i = 1; complete_idx_i = 2; op(); #1;
        chk("closed_complete", avail_o, 8'h07);
        @(negedge clk); #1;
        chk("closed_freed", avail_o, 8'h03);
        chk("closed_freed_idx", alloc_idx_o, 2);

`ifdef BSG_SCHEDULER_RESOURCE_AVAIL_BYPASS_EN
        alloc_yumi_i = 1; op();
        complete_v_i = 1; complete_idx_i = 2; #1;
        chk("bypass_same_cycle", avail_o, 8'h07);
        op();
`endif
        @(negedge clk);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bsg_scheduler_resource_avail.md
Name: bsg_scheduler_resource_avail

Overview:
Producer-side tracker that generates one resource's level-sensitive availability bitmap for a resource-readiness scheduler. It hands out dependency slot indices to producers, raises the slot's bit when the producer completes, and reference-counts consumers holding the index. Slots are recycled only after the producer closes the slot and all consumers have released it. One instance is used per resource; the `avail_o` outputs are concatenated into the scheduler's availability input.

Parameters:
- max_dep_bits_p, (required), bitmap width and number of slots; must be at least 2. Slot 0 is reserved.
- refcount_width_p, 4, width of the per-slot consumer reference counter.
- idx_width_lp, `BSG_SAFE_CLOG2(max_dep_bits_p), localparam, slot index width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- avail_o  out  max_dep_bits_p  availability bitmap; bit i = slot i is ready.
- alloc_v_o  out  1  a free slot is available.
- alloc_idx_o  out  idx_width_lp  index of the offered slot.
- alloc_yumi_i  in  1  producer takes the offered slot.
- complete_v_i  in  1  producer result is ready.
- complete_idx_i  in  idx_width_lp  slot being completed.
- ref_v_i  in  1  consumer takes a reference.
- ref_idx_i  in  idx_width_lp  slot being referenced.
- release_v_i  in  1  consumer drops a reference.
- release_idx_i  in  idx_width_lp  slot being released.
- close_v_i  in  1  producer will hand out no more references.
- close_idx_i  in  idx_width_lp  slot being closed.

Behaviour:
- Clocking: single clock `clk_i`; `reset_i` is synchronous and active-high. All state is registered.
- Per-slot state: state ∈ {FREE, PENDING, READY}, `closed_r` bit, `count_r[refcount_width_p]`.
- Slot 0:
  - Always reports available: `avail_o[0]` = 1.
  - Never offered for allocation.
  - All operations targeting index 0 are ignored.
- Reset and mid-operation reset:
  - Every slot goes to FREE, `closed_r` = 0, `count_r` = 0.
  - `avail_o` = 1 (only bit 0 set).
  - `alloc_v_o` = 1, `alloc_idx_o` = 1.
  - Any in-flight state is discarded.
- `avail_o[i]` (i ≥ 1) = (state_r[i] == READY). It is registered, so it rises the cycle after `complete_v_i`.
- Alloc:
  - `alloc_v_o` = any slot 1..N-1 is FREE; `alloc_idx_o` = lowest-indexed FREE slot. Both are combinational from registered state.
  - `alloc_yumi_i` is legal only when `alloc_v_o` = 1.
  - On yumi: slot → PENDING, `closed_r` = 0, `count_r` = 0.
  - Yumi while `alloc_v_o` = 0 is ignored and flagged by an assertion.
- Complete: PENDING → READY. Complete on a FREE or READY slot is ignored and flagged by an assertion.
- Ref: `count_r` +1, legal on PENDING or READY slots.
  - Ref on a FREE slot is ignored and asserted.
  - Ref at the saturated count (all ones) is ignored and asserted; no wrap.
- Release: `count_r` −1. Release at count 0 is ignored and asserted.
- Same-cycle ref and release to the same index: net change 0.
- Close: sets `closed_r`. Close on a FREE slot is ignored and asserted.
- Free condition: (registered) state_r == READY & `closed_r` & `count_r` == 0.
  - When true, the slot → FREE at the next edge.
  - Consequence: the slot spends at least one full cycle in READY with the condition true before clearing.
- Recycling timing: a slot that becomes FREE at edge t is offered no earlier than the cycle after edge t. Alloc never picks a slot freeing in the same cycle.
- Simultaneous events: complete, ref, release and close to distinct or identical slots may all occur in the same cycle. Each updates its own field independently.

Optional Feature:
- Macro: `BSG_SCHEDULER_RESOURCE_AVAIL_BYPASS_EN`.
- Defined: `avail_o[i]` also asserts combinationally in the same cycle when `complete_v_i` targets a PENDING slot i. This gives zero-latency wakeup.
- Undefined: `avail_o` is purely registered, with one cycle of completion-to-available latency.
- Free and alloc timing are unchanged either way.

Test Plan:
- Reset with max_dep_bits_p = 8 → `avail_o` = 8'h01, `alloc_v_o` = 1, `alloc_idx_o` = 1.
- Yumi slot 1, then `complete_v_i` idx 1 → `alloc_idx_o` = 2 the next cycle; `avail_o` = 8'h03 the cycle after complete (bypass undefined).
- Slot 1 READY: ref ×2, close, release ×1 → `avail_o[1]` stays 1. Second release at edge t → `avail_o[1]` = 0 after edge t+1; `alloc_idx_o` returns 1 after edge t+1.
- Allocate slots 1..7 → `alloc_v_o` = 0. Complete, close and free slot 5 → `alloc_v_o` = 1, `alloc_idx_o` = 5.
- Slot 3 at count 2: ref and release idx 3 in the same cycle → count 2 unchanged. Assert reset mid-sequence → `avail_o` = 8'h01, `alloc_idx_o` = 1.
- Bypass defined: `complete_v_i` idx 2 while slot 2 is PENDING → `avail_o[2]` = 1 in the same cycle.
